// File: rtl/pc_mt.sv
// Multi-thread round-robin fetch PC with stall, per-thread branch/halt and run/idle/done control.
// Optional build macro PC_WRAP_HALT_EN: a thread issued at the all-ones PC halts itself instead of wrapping.
module pc_mt #(
    parameter int                  PC_WIDTH    = 9,
    parameter int                  NUM_THREADS = 4,
    parameter int                  TID_WIDTH   = 2,
    parameter logic [PC_WIDTH-1:0] RESET_ADDR  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 branch_en,
    input  logic [TID_WIDTH-1:0] branch_thread,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic                 halt_en,
    input  logic [TID_WIDTH-1:0] halt_thread,
    output logic [PC_WIDTH-1:0]  pc_out,
    output logic [TID_WIDTH-1:0] tid_out,
    output logic                 pc_valid,
    output logic                 done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q [NUM_THREADS];
    logic [PC_WIDTH-1:0]    pc_d [NUM_THREADS];
    logic [NUM_THREADS-1:0] halted_q, halted_d;
    logic [TID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PC_WIDTH-1:0]    pc_out_q, pc_out_d;
    logic [TID_WIDTH-1:0]   tid_out_q, tid_out_d;
    logic                   pc_valid_q, pc_valid_d;

    logic [TID_WIDTH-1:0]   sel;
    logic                   sel_found;

    // First non-halted thread at or after rr_ptr, wrapping modulo NUM_THREADS.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            int idx;
            idx = (int'(rr_ptr_q) + i) % NUM_THREADS;
            if (!sel_found && !halted_q[idx]) begin
                sel_found = 1'b1;
                sel       = idx[TID_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through this block infers a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        halted_d   = halted_q;
        rr_ptr_d   = rr_ptr_q;
        pc_out_d   = pc_out_q;
        tid_out_d  = tid_out_q;
        pc_valid_d = pc_valid_q;

        case (state_q)
            S_IDLE: begin
                pc_valid_d = 1'b0;
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (!sel_found) begin
                    state_d    = S_DONE;
                    pc_valid_d = 1'b0;
                end else if (!stall) begin
                    pc_out_d   = pc_q[sel];
                    tid_out_d  = sel;
                    pc_valid_d = 1'b1;
                    rr_ptr_d   = (int'(sel) == NUM_THREADS - 1) ? '0 : sel + TID_WIDTH'(1);
`ifdef PC_WRAP_HALT_EN
                    if (&pc_q[sel]) begin
                        if (!(branch_en && branch_thread == sel)) halted_d[sel] = 1'b1;
                    end else begin
                        pc_d[sel] = pc_q[sel] + PC_WIDTH'(1);
                    end
`else
                    pc_d[sel] = pc_q[sel] + PC_WIDTH'(1);
`endif
                end
            end
            S_DONE: pc_valid_d = 1'b0;
            default: state_d = S_IDLE;
        endcase

        // A branch lands after the increment so it wins when it targets the issuing thread.
        if (branch_en && state_q != S_DONE && int'(branch_thread) < NUM_THREADS)
            pc_d[branch_thread] = branch_target;
        if (halt_en && int'(halt_thread) < NUM_THREADS)
            halted_d[halt_thread] = 1'b1;

        if (!start) begin
            state_d    = S_IDLE;
            halted_d   = '0;
            rr_ptr_d   = '0;
            pc_out_d   = RESET_ADDR;
            tid_out_d  = '0;
            pc_valid_d = 1'b0;
            for (int t = 0; t < NUM_THREADS; t++) pc_d[t] = RESET_ADDR;
        end
    end

    // NOTE: the PC file is reset like any other register because every thread must start from RESET_ADDR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            halted_q   <= '0;
            rr_ptr_q   <= '0;
            pc_out_q   <= RESET_ADDR;
            tid_out_q  <= '0;
            pc_valid_q <= 1'b0;
            for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= RESET_ADDR;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling this edge's pre-update values.
            state_q    <= state_d;
            halted_q   <= halted_d;
            rr_ptr_q   <= rr_ptr_d;
            pc_out_q   <= pc_out_d;
            tid_out_q  <= tid_out_d;
            pc_valid_q <= pc_valid_d;
            for (int t = 0; t < NUM_THREADS; t++) pc_q[t] <= pc_d[t];
        end
    end

    assign pc_out   = pc_out_q;
    assign tid_out  = tid_out_q;
    assign pc_valid = pc_valid_q;
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_pc_mt.sv
// Directed self-checking bench for pc_mt with default parameters (4 threads, 9-bit PC).
module tb_pc_mt;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stall;
    logic       branch_en;
    logic [1:0] branch_thread;
    logic [8:0] branch_target;
    logic       halt_en;
    logic [1:0] halt_thread;
    logic [8:0] pc_out;
    logic [1:0] tid_out;
    logic       pc_valid;
    logic       done;

    int total = 0;
    int bad   = 0;

    pc_mt dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stall        (stall),
        .branch_en    (branch_en),
        .branch_thread(branch_thread),
        .branch_target(branch_target),
        .halt_en      (halt_en),
        .halt_thread  (halt_thread),
        .pc_out       (pc_out),
        .tid_out      (tid_out),
        .pc_valid     (pc_valid),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] tid, input logic [8:0] pc,
                              input logic valid, input logic dn);
        check({tag, ".valid"}, 32'(pc_valid), 32'(valid));
        check({tag, ".done"},  32'(done),     32'(dn));
        if (valid) begin
            check({tag, ".tid"}, 32'(tid_out), 32'(tid));
            check({tag, ".pc"},  32'(pc_out),  32'(pc));
        end
    endtask

    task automatic issue(input string tag, input logic [1:0] tid, input logic [8:0] pc);
        tick();
        expect_out(tag, tid, pc, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0;
        branch_en = 1'b0; branch_thread = '0; branch_target = '0;
        halt_en = 1'b0; halt_thread = '0;
        #12;
        check("rst.pc",  32'(pc_out),  32'h0);
        check("rst.tid", 32'(tid_out), 32'h0);
        expect_out("rst", 2'd0, 9'h0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        start = 1'b1;

        // IDLE -> RUN edge does not issue yet.
        tick();
        expect_out("start", 2'd0, 9'h0, 1'b0, 1'b0);
        issue("rr0", 2'd0, 9'h0);
        issue("rr1", 2'd1, 9'h0);
        issue("rr2", 2'd2, 9'h0);
        issue("rr3", 2'd3, 9'h0);
        issue("rr4", 2'd0, 9'h1);
        issue("rr5", 2'd1, 9'h1);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out($sformatf("stall%0d", i), 2'd1, 9'h1, 1'b1, 1'b0);
        end
        stall = 1'b0;
        issue("res0", 2'd2, 9'h1);
        issue("res1", 2'd3, 9'h1);
        issue("res2", 2'd0, 9'h2);
        issue("res3", 2'd1, 9'h2);

        // Branch thread 2 on the cycle it issues: issue shows old PC, next issue the target.
        branch_en = 1'b1; branch_thread = 2'd2; branch_target = 9'h1F0;
        issue("br_old", 2'd2, 9'h2);
        branch_en = 1'b0;
        issue("br1", 2'd3, 9'h2);
        issue("br2", 2'd0, 9'h3);
        issue("br3", 2'd1, 9'h3);
        issue("br_new", 2'd2, 9'h1F0);

        // Halt threads 1 and 3 while stalled.
        stall = 1'b1; halt_en = 1'b1; halt_thread = 2'd1;
        tick();
        expect_out("hstall0", 2'd2, 9'h1F0, 1'b1, 1'b0);
        halt_thread = 2'd3;
        tick();
        expect_out("hstall1", 2'd2, 9'h1F0, 1'b1, 1'b0);
        stall = 1'b0; halt_en = 1'b0;
        issue("h0", 2'd0, 9'h4);
        issue("h1", 2'd2, 9'h1F1);
        issue("h2", 2'd0, 9'h5);
        issue("h3", 2'd2, 9'h1F2);
        halt_en = 1'b1; halt_thread = 2'd0;
        issue("hlast0", 2'd0, 9'h6);
        halt_thread = 2'd2;
        issue("hlast1", 2'd2, 9'h1F3);
        halt_en = 1'b0;
        tick();
        expect_out("done0", 2'd0, 9'h0, 1'b0, 1'b1);
        tick();
        expect_out("done1", 2'd0, 9'h0, 1'b0, 1'b1);

        // Restart: all PCs and halt flags return to reset values.
        start = 1'b0;
        tick();
        check("idle.pc",  32'(pc_out),  32'h0);
        check("idle.tid", 32'(tid_out), 32'h0);
        expect_out("idle", 2'd0, 9'h0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        expect_out("rerun", 2'd0, 9'h0, 1'b0, 1'b0);
        issue("rs0", 2'd0, 9'h0);
        issue("rs1", 2'd1, 9'h0);
        issue("rs2", 2'd2, 9'h0);
        issue("rs3", 2'd3, 9'h0);

        // Wrap at the all-ones PC.
        branch_en = 1'b1; branch_thread = 2'd0; branch_target = 9'h1FF;
        issue("w0", 2'd0, 9'h1);
        branch_en = 1'b0;
        issue("w1", 2'd1, 9'h1);
        issue("w2", 2'd2, 9'h1);
        issue("w3", 2'd3, 9'h1);
        issue("wtop", 2'd0, 9'h1FF);
        issue("w5", 2'd1, 9'h2);
        issue("w6", 2'd2, 9'h2);
        issue("w7", 2'd3, 9'h2);
`ifdef PC_WRAP_HALT_EN
        issue("wskip", 2'd1, 9'h3);
`else
        issue("wwrap", 2'd0, 9'h0);
`endif

        // Asynchronous reset between edges.
        #3;
        reset = 1'b1;
        #1;
        check("arst.pc",  32'(pc_out),  32'h0);
        check("arst.tid", 32'(tid_out), 32'h0);
        expect_out("arst", 2'd0, 9'h0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
